// File: rtl/risc_alu_if.sv
// risc_alu_if: operand/result bundle between the RISC datapath and its ALU.
//   Ain, Bin : operands from the A-side and B-side source muxes
//   ALUop    : operation select (00 add, 01 sub, 10 and, 11 not-B)
//   loads    : status register load enable
//   out, Z   : combinational result and zero flag
//   status   : registered {V,N,Z}
// master drives the operands, slave (the ALU) drives the results.
interface risc_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [1:0]       ALUop;
    logic             loads;
    logic [WIDTH-1:0] out;
    logic             Z;
    logic [2:0]       status;

    modport master (
        output Ain, Bin, ALUop, loads,
        input  out, Z, status
    );

    modport slave (
        input  Ain, Bin, ALUop, loads,
        output out, Z, status
    );
endinterface

// File: rtl/risc_alu.sv
// risc_alu: WIDTH-bit ALU for the simple RISC datapath.
//   clk   : rising-edge clock for the status register
//   reset : asynchronous active-high clear of the status register
//   bus   : risc_alu_if slave port (Ain, Bin, ALUop, loads in;
//           out, Z, status out)
// out and Z are purely combinational. status = {V,N,Z} is captured
// on a rising clk edge when loads is high and is unaffected otherwise.
module risc_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    risc_alu_if.slave   bus
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_NOT = 2'b11
    } alu_op_e;

    alu_op_e          w_op;
    logic [WIDTH-1:0] w_out;
    logic             w_z;
    logic             w_nn;
    logic             w_vn;
    logic             w_a_msb;
    logic             w_b_msb;
    logic             w_o_msb;
    logic [2:0]       r_status;

    assign w_op = alu_op_e'(bus.ALUop);

    always_comb begin
        w_out = '0;
        case (w_op)
            OP_ADD:  w_out = bus.Ain + bus.Bin;
            OP_SUB:  w_out = bus.Ain - bus.Bin;
            OP_AND:  w_out = bus.Ain & bus.Bin;
            OP_NOT:  w_out = ~bus.Bin;
            default: w_out = '0;
        endcase
    end

    assign w_z     = (w_out == '0);
    assign w_nn    = w_out[WIDTH-1];
    assign w_a_msb = bus.Ain[WIDTH-1];
    assign w_b_msb = bus.Bin[WIDTH-1];
    assign w_o_msb = w_out[WIDTH-1];

    // Signed overflow: add overflows when like-signed operands give a
    // result of the other sign; sub when unlike-signed operands do.
    always_comb begin
        w_vn = 1'b0;
        case (w_op)
            OP_ADD:  w_vn = (w_a_msb == w_b_msb) && (w_o_msb != w_a_msb);
            OP_SUB:  w_vn = (w_a_msb != w_b_msb) && (w_o_msb != w_a_msb);
            default: w_vn = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= '0;
        end else if (bus.loads) begin
            r_status <= {w_vn, w_nn, w_z};
        end
    end

    assign bus.out    = w_out;
    assign bus.Z      = w_z;
    assign bus.status = r_status;
endmodule

// File: tb/tb_risc_alu.sv
// tb_risc_alu: directed-vector bench for risc_alu. Expected values are
// hand-computed constants.
module tb_risc_alu;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    risc_alu_if #(.WIDTH(16)) bus ();

    risc_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op);
        bus.Ain   = a;
        bus.Bin   = b;
        bus.ALUop = op;
        #1;
    endtask

    // Apply operands with loads high across one rising edge.
    task automatic load_edge(input logic [15:0] a, input logic [15:0] b,
                             input logic [1:0] op);
        @(negedge clk);
        drive(a, b, op);
        bus.loads = 1'b1;
        @(posedge clk);
        #1;
        bus.loads = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.loads = 1'b0;
        drive(16'h0000, 16'h0000, 2'b00);
        check_val("reset_status", {13'd0, bus.status}, 16'h0000);

        @(negedge clk);
        reset = 1'b0;

        drive(16'hF0CF, 16'hB965, 2'b00);
        check_val("add_out", bus.out, 16'hAA34);
        check_val("add_z", {15'd0, bus.Z}, 16'h0000);
        drive(16'hF0CF, 16'hB965, 2'b01);
        check_val("sub_out", bus.out, 16'h376A);
        check_val("sub_z", {15'd0, bus.Z}, 16'h0000);
        drive(16'hF0CF, 16'hF0CF, 2'b01);
        check_val("sub0_out", bus.out, 16'h0000);
        check_val("sub0_z", {15'd0, bus.Z}, 16'h0001);
        drive(16'hF0CF, 16'hB965, 2'b10);
        check_val("and_out", bus.out, 16'hB045);
        check_val("and_z", {15'd0, bus.Z}, 16'h0000);
        drive(16'hF0CF, 16'hB965, 2'b11);
        check_val("not_out", bus.out, 16'h469A);
        check_val("not_z", {15'd0, bus.Z}, 16'h0000);
        drive(16'h1234, 16'hFFFF, 2'b11);
        check_val("not0_out", bus.out, 16'h0000);
        check_val("not0_z", {15'd0, bus.Z}, 16'h0001);
        drive(16'h0000, 16'h0000, 2'b10);
        check_val("and0_out", bus.out, 16'h0000);
        check_val("and0_z", {15'd0, bus.Z}, 16'h0001);

        // status register captures
        load_edge(16'h7FFF, 16'h0001, 2'b00);
        check_val("st_add_ovf", {13'd0, bus.status}, 16'h0006);
        load_edge(16'h8000, 16'h0001, 2'b01);
        check_val("st_sub_ovf", {13'd0, bus.status}, 16'h0004);
        check_val("sub_ovf_out", bus.out, 16'h7FFF);
        load_edge(16'h8000, 16'h8000, 2'b00);
        check_val("st_add_negovf", {13'd0, bus.status}, 16'h0005);
        load_edge(16'hFFFF, 16'h8000, 2'b10);
        check_val("st_and_neg", {13'd0, bus.status}, 16'h0002);
        load_edge(16'h1234, 16'h1234, 2'b01);
        check_val("st_sub_zero", {13'd0, bus.status}, 16'h0001);

        // hold with loads low
        @(negedge clk);
        drive(16'h7FFF, 16'h0001, 2'b00);
        @(posedge clk);
        #1;
        check_val("st_hold", {13'd0, bus.status}, 16'h0001);

        // asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("st_async_rst", {13'd0, bus.status}, 16'h0000);
        drive(16'h0001, 16'h0002, 2'b00);
        check_val("rst_out", bus.out, 16'h0003);
        check_val("rst_z", {15'd0, bus.Z}, 16'h0000);
        drive(16'h5555, 16'h5555, 2'b01);
        check_val("rst_out0", bus.out, 16'h0000);
        check_val("rst_z0", {15'd0, bus.Z}, 16'h0001);

        // load edge during reset: reset wins
        load_edge(16'h7FFF, 16'h0001, 2'b00);
        check_val("st_rst_wins", {13'd0, bus.status}, 16'h0000);

        // release reset, no load: stays cleared
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("st_after_rst", {13'd0, bus.status}, 16'h0000);
        load_edge(16'h7FFF, 16'h0001, 2'b00);
        check_val("st_reload", {13'd0, bus.status}, 16'h0006);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
